// File: rtl/core_debug_sync_ctrl.sv
// -----------------------------------------------------------------------------
// core_debug_sync_ctrl
//
// Cross-core debug halt synchronizer. Watches each core's debugack. When an
// enabled core enters debug mode, it raises debugreq to every other
// participating core until all of them are halted or a timeout expires. After
// the debugger resumes every core, a holdoff window ignores further triggers
// so that late-resuming or re-entering cores do not start a new sync.
//
// Ports:
//   clk           system clock (single domain)
//   reset_n       asynchronous active-low reset
//   sync_en       enables cross-halting; dropping it in HALTING aborts the sync
//   core_mask     participating cores, captured at trigger
//   debugack      per-core debug-mode acknowledge
//   clr_status    pulse; clears origin_valid and timeout_err
//   debugreq      per-core halt request (registered)
//   sync_busy     high while in HALTING
//   all_halted    high while in HALTED
//   origin_id     lowest-index core that triggered the last sync
//   origin_valid  sticky, origin_id is meaningful
//   timeout_err   sticky, the last HALTING ended by timeout
// -----------------------------------------------------------------------------
module core_debug_sync_ctrl #(
    parameter int NUM_CORES      = 7,
    parameter int ID_W           = 3,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int HOLDOFF_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sync_en,
    input  logic [NUM_CORES-1:0] core_mask,
    input  logic [NUM_CORES-1:0] debugack,
    input  logic                 clr_status,
    output logic [NUM_CORES-1:0] debugreq,
    output logic                 sync_busy,
    output logic                 all_halted,
    output logic [ID_W-1:0]      origin_id,
    output logic                 origin_valid,
    output logic                 timeout_err
);

    // Counter is shared between the HALTING timeout and the HOLDOFF window.
    localparam int CNT_MAX = (TIMEOUT_CYCLES > HOLDOFF_CYCLES) ? TIMEOUT_CYCLES : HOLDOFF_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HALTING = 2'd1,
        ST_HALTED  = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_CORES-1:0] ack_dly_q;
    logic [NUM_CORES-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_CORES-1:0] debugreq_q, debugreq_d;
    logic [ID_W-1:0]      origin_id_q, origin_id_d;
    logic                 origin_valid_q, origin_valid_d;
    logic                 timeout_err_q, timeout_err_d;

    logic [NUM_CORES-1:0] rise;
    logic [ID_W-1:0]      rise_idx;
    logic                 all_acked;

    // Rising edge of debugack, restricted to the live mask (mask_q only
    // matters after trigger; before that the current core_mask decides).
    assign rise      = debugack & ~ack_dly_q & core_mask;
    assign all_acked = &(debugack | ~mask_q);

    // Lowest set index wins; scanning downward lets the last hit be the lowest.
    always_comb begin
        rise_idx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (rise[i]) begin
                rise_idx = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        cnt_d         = cnt_q;
        debugreq_d    = '0;
        origin_id_d   = origin_id_q;
        // Clear first so that any set below overrides it in the same cycle.
        origin_valid_d = clr_status ? 1'b0 : origin_valid_q;
        timeout_err_d  = clr_status ? 1'b0 : timeout_err_q;

        case (state_q)
            ST_IDLE: begin
                if (sync_en && (|rise)) begin
                    mask_d         = core_mask;
                    origin_id_d    = rise_idx;
                    origin_valid_d = 1'b1;
                    cnt_d          = '0;
                    debugreq_d     = core_mask & ~debugack;
                    state_d        = ST_HALTING;
                end
            end
            ST_HALTING: begin
                if (!sync_en) begin
                    state_d = ST_HALTED;
                end else if (all_acked) begin
                    state_d = ST_HALTED;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_HALTED;
                end else begin
                    debugreq_d = mask_q & ~debugack;
                    cnt_d      = cnt_q + 1'b1;
                end
            end
            ST_HALTED: begin
                if ((debugack & mask_q) == '0) begin
                    cnt_d   = '0;
                    state_d = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == HOLDOFF_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            ack_dly_q      <= '0;
            mask_q         <= '0;
            cnt_q          <= '0;
            debugreq_q     <= '0;
            origin_id_q    <= '0;
            origin_valid_q <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            ack_dly_q      <= debugack;
            mask_q         <= mask_d;
            cnt_q          <= cnt_d;
            debugreq_q     <= debugreq_d;
            origin_id_q    <= origin_id_d;
            origin_valid_q <= origin_valid_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign debugreq     = debugreq_q;
    assign sync_busy    = (state_q == ST_HALTING);
    assign all_halted   = (state_q == ST_HALTED);
    assign origin_id    = origin_id_q;
    assign origin_valid = origin_valid_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_core_debug_sync_ctrl.sv
// -----------------------------------------------------------------------------
// tb_core_debug_sync_ctrl
//
// Directed bench for core_debug_sync_ctrl with TIMEOUT_CYCLES=8 and
// HOLDOFF_CYCLES=16. Inputs change 1ns after a rising edge and outputs are
// checked at that same point, so each "step" advances exactly one clock edge.
// -----------------------------------------------------------------------------
module tb_core_debug_sync_ctrl;

    localparam int NC = 7;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          sync_en;
    logic [NC-1:0] core_mask;
    logic [NC-1:0] debugack;
    logic          clr_status;
    logic [NC-1:0] debugreq;
    logic          sync_busy;
    logic          all_halted;
    logic [IW-1:0] origin_id;
    logic          origin_valid;
    logic          timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    core_debug_sync_ctrl #(
        .NUM_CORES      (NC),
        .ID_W           (IW),
        .TIMEOUT_CYCLES (8),
        .HOLDOFF_CYCLES (16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sync_en      (sync_en),
        .core_mask    (core_mask),
        .debugack     (debugack),
        .clr_status   (clr_status),
        .debugreq     (debugreq),
        .sync_busy    (sync_busy),
        .all_halted   (all_halted),
        .origin_id    (origin_id),
        .origin_valid (origin_valid),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, obs);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n    = 1'b0;
        sync_en    = 1'b0;
        core_mask  = '0;
        debugack   = '0;
        clr_status = 1'b0;
        step(3);

        // Reset state
        check_eq("rst_debugreq",   debugreq,     0);
        check_eq("rst_busy",       sync_busy,    0);
        check_eq("rst_halted",     all_halted,   0);
        check_eq("rst_origin_vld", origin_valid, 0);
        check_eq("rst_timeout",    timeout_err,  0);
        reset_n = 1'b1;
        step(2);

        // ---------------- Basic cross-halt, core 3 triggers -------------
        core_mask = 7'h7F;
        sync_en   = 1'b1;
        debugack  = 7'h08;
        step(1);                                  // trigger edge
        check_eq("basic_debugreq", debugreq,  7'h77);
        check_eq("basic_busy",     sync_busy, 1);
        check_eq("basic_origin",   origin_id, 3);
        check_eq("basic_orig_vld", origin_valid, 1);
        step(3);
        debugack = 7'h09;                         // core 0 acks alone
        step(1);
        check_eq("basic_drop_c0",  debugreq,  7'h76);
        check_eq("basic_busy2",    sync_busy, 1);
        debugack = 7'h7F;                         // remaining cores ack
        step(1);
        check_eq("basic_req_done", debugreq,  0);
        check_eq("basic_halted",   all_halted, 1);
        check_eq("basic_busy_off", sync_busy, 0);
        check_eq("basic_no_tmo",   timeout_err, 0);

        // ---------------- Resume and holdoff ----------------------------
        debugack = '0;                            // release at R
        step(1);                                  // HALTED -> HOLDOFF
        check_eq("hold_not_halted", all_halted, 0);
        step(2);
        debugack = 7'h40;                         // core 6 re-enters at R+3
        step(1);
        check_eq("hold_no_trig",   sync_busy, 0);
        check_eq("hold_no_req",    debugreq,  0);
        step(2);
        debugack = '0;
        step(14);                                 // now R+20, back in IDLE
        check_eq("hold_idle_busy", sync_busy, 0);
        debugack = 7'h40;
        step(1);
        check_eq("retrig_busy",    sync_busy, 1);
        check_eq("retrig_origin",  origin_id, 6);
        check_eq("retrig_req",     debugreq,  7'h3F);
        debugack = 7'h7F;
        step(1);
        check_eq("retrig_halted",  all_halted, 1);
        debugack = '0;
        step(20);

        // ---------------- Timeout: core 5 never acks --------------------
        debugack = 7'h01;
        step(1);                                  // trigger, cnt=0
        check_eq("tmo_req",        debugreq,  7'h7E);
        check_eq("tmo_origin",     origin_id, 0);
        debugack = 7'h5F;
        step(1);
        check_eq("tmo_req_c5",     debugreq,  7'h20);
        step(6);                                  // 7 edges in HALTING
        check_eq("tmo_still_busy", sync_busy, 1);
        check_eq("tmo_not_yet",    timeout_err, 0);
        step(1);                                  // 8th edge: timeout
        check_eq("tmo_err",        timeout_err, 1);
        check_eq("tmo_halted",     all_halted, 1);
        check_eq("tmo_req_zero",   debugreq,  0);
        clr_status = 1'b1;
        step(1);
        clr_status = 1'b0;
        check_eq("clr_tmo",        timeout_err, 0);
        check_eq("clr_orig_vld",   origin_valid, 0);
        debugack = '0;
        step(20);

        // ---------------- Simultaneous triggers with mask ---------------
        core_mask = 7'h3C;
        debugack  = 7'h02;                        // unmasked core alone
        step(1);
        check_eq("mask_ignore",    sync_busy, 0);
        debugack  = 7'h16;                        // cores 1,2,4 (1 still masked out)
        step(1);
        check_eq("simul_origin",   origin_id, 2);
        check_eq("simul_busy",     sync_busy, 1);
        // mask & ~debugack = 0x3C & ~0x16
        check_eq("simul_req",      debugreq,  7'h28);
        core_mask = 7'h7F;                        // late mask change, no effect
        step(1);
        check_eq("simul_req2",     debugreq,  7'h28);

        // ---------------- Abort by dropping sync_en ---------------------
        sync_en = 1'b0;
        step(1);
        check_eq("abort_req",      debugreq,  0);
        check_eq("abort_halted",   all_halted, 1);
        check_eq("abort_no_tmo",   timeout_err, 0);
        sync_en  = 1'b1;
        debugack = '0;
        step(20);

        // ---------------- Set beats clear -------------------------------
        clr_status = 1'b1;
        debugack   = 7'h20;
        step(1);
        clr_status = 1'b0;
        check_eq("setclr_vld",     origin_valid, 1);
        check_eq("setclr_origin",  origin_id, 5);
        check_eq("setclr_busy",    sync_busy, 1);

        // ---------------- Asynchronous reset mid-HALTING ----------------
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_req",       debugreq,  0);
        check_eq("arst_busy",      sync_busy, 0);
        check_eq("arst_vld",       origin_valid, 0);
        check_eq("arst_origin",    origin_id, 0);
        step(1);
        reset_n = 1'b1;
        step(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
